// File: rtl/gpio_in_filter_pkg.sv
// Shared GPIO input-filter definitions: pin count, debounce counter width and
// the filter configuration payload.
package gpio_in_filter_pkg;

  localparam int unsigned GPIO_NUM_PINS = 8;
  localparam int unsigned GPIO_DB_CNT_W = 16;

  // Per-block filter configuration as carried from the register block.
  typedef struct packed {
    logic [GPIO_NUM_PINS-1:0] db_en;
    logic [GPIO_DB_CNT_W-1:0] db_limit;
  } type_gpio_filt_cfg_s;

endpackage : gpio_in_filter_pkg

// File: rtl/gpio_in_filter_pin.sv
// Single-pin input conditioner: 2-flop synchroniser, debounce counter and
// registered level / edge outputs.
// Optional feature: GPIO_EDGE_DET_EN builds the rise/fall pulse registers;
// otherwise rise_o/fall_o are tied low.
module gpio_in_filter_pin
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned DB_CNT_W = GPIO_DB_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pad_i,
  input  logic                db_en_i,
  input  logic [DB_CNT_W-1:0] db_limit_i,
  output logic                pin_o,
  output logic                rise_o,
  output logic                fall_o
);

  // One extra bit so cnt+1 can never wrap before the compare.
  localparam int unsigned CntExtW = DB_CNT_W + 1;

  logic                s1_q;
  logic                s2_q;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;
  logic                pin_q;
  logic                pin_d;
  logic [CntExtW-1:0]  cnt_inc;
  logic                bypass;

  // Synchroniser; s2_q is the only pad-derived value used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pad_i;
      s2_q <= s1_q;
    end
  end

  // Debounce decision: follow s2 directly in bypass, else require db_limit_i
  // consecutive mismatching cycles before committing.
  always_comb begin
    pin_d   = pin_q;
    cnt_d   = '0;
    cnt_inc = {1'b0, cnt_q} + CntExtW'(1);
    bypass  = !db_en_i || (db_limit_i == '0);
    if (bypass) begin
      pin_d = s2_q;
    end else if (s2_q != pin_q) begin
      if (cnt_inc >= {1'b0, db_limit_i}) begin
        pin_d = s2_q;
      end else begin
        cnt_d = cnt_inc[DB_CNT_W-1:0];
      end
    end
  end

  // Counter and filtered level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pin_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pin_q <= pin_d;
    end
  end

  assign pin_o = pin_q;

`ifdef GPIO_EDGE_DET_EN
  logic rise_q;
  logic fall_q;

  // Edge pulses registered alongside pin_q so they align with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= pin_d & ~pin_q;
      fall_q <= ~pin_d & pin_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule : gpio_in_filter_pin

// File: rtl/gpio_in_filter.sv
// GPIO pad input conditioning: one synchronise/debounce/edge stage per pin.
// Optional feature: GPIO_EDGE_DET_EN enables rise_o/fall_o pulses; without it
// those ports are present but constant zero.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned NUM_PINS = GPIO_NUM_PINS,
  parameter int unsigned DB_CNT_W = GPIO_DB_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PINS-1:0] pad_i,
  input  logic [NUM_PINS-1:0] db_en_i,
  input  logic [DB_CNT_W-1:0] db_limit_i,
  output logic [NUM_PINS-1:0] pin_o,
  output logic [NUM_PINS-1:0] rise_o,
  output logic [NUM_PINS-1:0] fall_o
);

  // Independent filter per pin; only db_limit_i is shared.
  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    gpio_in_filter_pin #(
      .DB_CNT_W (DB_CNT_W)
    ) u_pin (
      .clk        (clk),
      .rst_n      (rst_n),
      .pad_i      (pad_i[gi]),
      .db_en_i    (db_en_i[gi]),
      .db_limit_i (db_limit_i),
      .pin_o      (pin_o[gi]),
      .rise_o     (rise_o[gi]),
      .fall_o     (fall_o[gi])
    );
  end

endmodule : gpio_in_filter

// File: tb/tb_gpio_in_filter.sv
// Directed self-checking bench for gpio_in_filter.
module tb_gpio_in_filter;

`ifdef GPIO_EDGE_DET_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  pad_i;
  logic [7:0]  db_en_i;
  logic [15:0] db_limit_i;
  logic [7:0]  pin_o;
  logic [7:0]  rise_o;
  logic [7:0]  fall_o;

  int checks = 0;
  int errors = 0;

  gpio_in_filter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_i      (pad_i),
    .db_en_i    (db_en_i),
    .db_limit_i (db_limit_i),
    .pin_o      (pin_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pad_i = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] edge_exp(input logic [7:0] m);
    return EdgeEn ? m : 8'h00;
  endfunction

  int rise_cnt;

  initial begin
    rst_n      = 1'b0;
    pad_i      = '0;
    db_en_i    = '0;
    db_limit_i = '0;
    #2;
    check("reset_pin",  32'(pin_o),  32'h0);
    check("reset_rise", 32'(rise_o), 32'h0);
    check("reset_fall", 32'(fall_o), 32'h0);
    do_reset();

    // 1: bypass, 3-edge latency
    pad_i[0] = 1'b1;
    tick(); check("byp_e1", 32'(pin_o), 32'h00);
    tick(); check("byp_e2", 32'(pin_o), 32'h00);
    tick(); check("byp_e3", 32'(pin_o), 32'h01);
    check("byp_rise", 32'(rise_o), 32'(edge_exp(8'h01)));
    tick(); check("byp_rise_end", 32'(rise_o), 32'h00);
    pad_i[0] = 1'b0;
    tick(); tick(); tick();
    check("byp_fall_pin", 32'(pin_o), 32'h00);
    check("byp_fall", 32'(fall_o), 32'(edge_exp(8'h01)));

    // 2: debounce limit 4 -> 6 edges
    do_reset();
    db_en_i = 8'hFF; db_limit_i = 16'd4;
    pad_i[3] = 1'b1;
    rise_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("db_pin_e%0d", i), 32'(pin_o[3]), (i >= 6) ? 32'h1 : 32'h0);
      if (rise_o[3]) rise_cnt++;
      if (rise_o[3] && fall_o[3]) check("db_both", 32'h1, 32'h0);
    end
    check("db_rise_count", 32'(rise_cnt), EdgeEn ? 32'd1 : 32'd0);

    // 3: glitch shorter than limit is rejected
    do_reset();
    pad_i[5] = 1'b1;
    tick(); tick(); tick();
    pad_i[5] = 1'b0;
    rise_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pin_o[5] || rise_o[5] || fall_o[5]) rise_cnt++;
    end
    check("glitch_quiet", 32'(rise_cnt), 32'd0);

    // 4: lowering limit below a running count commits next cycle
    do_reset();
    db_limit_i = 16'd10;
    pad_i[1] = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("lim_pre", 32'(pin_o[1]), 32'h0);
    db_limit_i = 16'd3;
    tick();
    check("lim_commit", 32'(pin_o[1]), 32'h1);
    check("lim_rise", 32'(rise_o), 32'(edge_exp(8'h02)));
    pad_i[1] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("lim_fall_pre", 32'(pin_o[1]), 32'h1);
    tick();
    check("lim_fall_pin", 32'(pin_o[1]), 32'h0);
    check("lim_fall", 32'(fall_o), 32'(edge_exp(8'h02)));

    // 5: multi-pin mixed bypass/debounce
    do_reset();
    db_en_i = 8'h0F; db_limit_i = 16'd5;
    pad_i = 8'hA5;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("mp_pin_e%0d", i), 32'(pin_o),
            (i >= 7) ? 32'hA5 : (i >= 3) ? 32'hA0 : 32'h00);
      check($sformatf("mp_rise_e%0d", i), 32'(rise_o),
            (i == 7) ? 32'(edge_exp(8'h05)) : (i == 3) ? 32'(edge_exp(8'hA0)) : 32'h00);
    end

    // 6: reset mid-count, then re-qualification
    do_reset();
    db_en_i = 8'hFF; db_limit_i = 16'd4;
    pad_i[4] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    pad_i[7] = 1'b1;
    tick();
    pad_i[7] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_async_pin",  32'(pin_o),  32'h0);
    check("rst_async_rise", 32'(rise_o), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rst_req_pre", 32'(pin_o), 32'h00);
    tick();
    check("rst_req_pin", 32'(pin_o), 32'h90);
    check("rst_req_rise", 32'(rise_o), 32'(edge_exp(8'h90)));
    tick();
    check("rst_req_rise_end", 32'(rise_o), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gpio_in_filter
